btn_autorepeat: RTL
===================

BTN_AUTOREPEAT -- requirements
Module: btn_autorepeat

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning input-stable time before the debounced level changes (20 ms at 50 MHz).
REQ-002 SHALL have parameter DAS_CYCLES, default 8500000, meaning delay from press to first auto-repeat (170 ms).
REQ-003 SHALL have parameter ARR_CYCLES, default 2500000, meaning period between subsequent auto-repeats (50 ms).
REQ-004 SHALL have port clk  input  1  the single 50 MHz clock (clk_50MHz domain); all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port usr_btn  input  4  raw asynchronous push-buttons, active-high.
REQ-007 SHALL have port repeat_en  input  4  per-button auto-repeat enable.
REQ-008 SHALL have port btn_level  output  4  debounced, registered button level.
REQ-009 SHALL have port btn_press  output  4  one-cycle pulse per debounced press.
REQ-010 SHALL have port btn_fire  output  4  one-cycle pulse on press and on each auto-repeat; consumed by control.

Function
REQ-011 SHALL pass each usr_btn bit through a 2-flop synchronizer; the second flop is the "synced" input.
REQ-012 SHALL run a per-button debounce counter: cleared when synced == btn_level; incremented when they differ.
REQ-013 SHALL toggle btn_level[i] and clear the counter when synced differs and the counter equals DEBOUNCE_CYCLES-1, so the level follows after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-014 SHALL give fixed latency: raw edge held stable -> btn_level change exactly 2+DEBOUNCE_CYCLES cycles later.
REQ-015 SHALL discard glitches shorter than DEBOUNCE_CYCLES; btn_level does not change.
REQ-016 SHALL assert btn_press[i] and btn_fire[i] only in the cycle btn_level[i] first reads 1 (cycle T).
REQ-017 SHALL run a per-button FSM with states REL, DELAY and REPEAT.
REQ-018 SHALL take REL -> DELAY on the debounced rise, with the repeat counter cleared.
REQ-019 SHALL take DELAY -> REPEAT at cycle T+DAS_CYCLES, pulsing btn_fire.
REQ-020 SHALL, in REPEAT, pulse btn_fire every ARR_CYCLES: at T+DAS_CYCLES+k*ARR_CYCLES for k>=1.
REQ-021 SHALL go to REL from any state on the debounced fall (btn_level 1->0); no fire in that cycle or after.
REQ-022 SHALL let release win over a coincident scheduled repeat: no pulse.
REQ-023 SHALL, while repeat_en[i]=0, hold the repeat counter at 0 in DELAY/REPEAT with no repeat pulses; on re-enable, timing restarts from that cycle in the current state.
REQ-024 SHALL operate the four buttons independently; simultaneous presses give simultaneous pulses.
REQ-025 SHALL size counters with $clog2 of the largest parameter; no wrap while held (REPEAT counter reloads each period).

Reset
REQ-026 SHALL, with reset_n=0 at a clock edge, clear synchronizers, counters, btn_level, btn_press and btn_fire to 0 and put all FSMs in REL.
REQ-027 SHALL, on reset mid-hold, require a full 2+DEBOUNCE_CYCLES again after reset release for a still-held button, then produce a fresh press.

Structure
REQ-028 SHALL define enum rep_state_t {REL, DELAY, REPEAT} in the shared enum_type package.
REQ-029 SHALL implement one button as sub-module btn_channel (sync, debounce, FSM), instantiated 4 times by generate.
REQ-030 SHALL contain no combinational output paths; all outputs are registered.

Verification (DEBOUNCE_CYCLES=4, DAS_CYCLES=10, ARR_CYCLES=3)
REQ-031 SHALL cover: usr_btn[0] rises at cycle 0, held 40 cycles -> btn_level[0] high at 6; btn_fire[0] at 6, 16, 19, 22, ...; btn_press[0] only at 6.
REQ-032 SHALL cover: 3-cycle high glitch on usr_btn[1] -> btn_level, btn_press and btn_fire stay 0.
REQ-033 SHALL cover: release so btn_level falls exactly on a scheduled repeat cycle -> no pulse then or later; FSM in REL.
REQ-034 SHALL cover: repeat_en[2]=0 while held 30 cycles -> single fire at press only; set repeat_en[2]=1 at cycle R -> next fire at R+10.
REQ-035 SHALL cover: buttons 0 and 3 pressed same cycle -> identical pulse trains on bits 0 and 3.
REQ-036 SHALL cover: reset_n low for 1 cycle mid-REPEAT with button held -> all outputs 0 next cycle; fresh press pulse 6 cycles after reset release.

Source files
------------

// File: rtl/btn_autorepeat_pkg.sv
// Shared types and sizing helpers for the button auto-repeat block.
package btn_autorepeat_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        REL,
        DELAY,
        REPEAT
    } rep_state_t;

    // Width wide enough to hold (largest period - 1); never below 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_autorepeat_if.sv
// Button bus: raw inputs and enables in, debounced level and pulses out.
interface btn_autorepeat_if;

    logic [btn_autorepeat_pkg::NUM_BTN-1:0] usr_btn;
    logic [btn_autorepeat_pkg::NUM_BTN-1:0] repeat_en;
    logic [btn_autorepeat_pkg::NUM_BTN-1:0] btn_level;
    logic [btn_autorepeat_pkg::NUM_BTN-1:0] btn_press;
    logic [btn_autorepeat_pkg::NUM_BTN-1:0] btn_fire;

    modport master (
        output usr_btn, repeat_en,
        input  btn_level, btn_press, btn_fire
    );

    modport slave (
        input  usr_btn, repeat_en,
        output btn_level, btn_press, btn_fire
    );

endinterface

// File: rtl/btn_autorepeat_channel.sv
// One button: 2-flop synchronizer, debounce counter and DAS/ARR repeat FSM.
module btn_channel import btn_autorepeat_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DAS_CYCLES      = 8500000,
    parameter int ARR_CYCLES      = 2500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic usr_btn_i,
    input  logic repeat_en_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_fire_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, DAS_CYCLES, ARR_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    rep_state_t    state_q, state_d;
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          press_q, press_d;
    logic          fire_q, fire_d;
    logic          rise, fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= REL;
            rpt_cnt_q <= '0;
            press_q   <= 1'b0;
            fire_q    <= 1'b0;
        end else begin
            sync1_q   <= usr_btn_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            press_q   <= press_d;
            fire_q    <= fire_d;
        end
    end

    // Debounce: count consecutive cycles where synced input disagrees with level.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Pulses are decided from the next level so they line up with btn_level;
    // a fall always wins over a repeat scheduled for the same edge.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        press_d   = 1'b0;
        fire_d    = 1'b0;
        if (fall) begin
            state_d   = REL;
            rpt_cnt_d = '0;
        end else begin
            case (state_q)
                REL: begin
                    rpt_cnt_d = '0;
                    if (rise) begin
                        state_d = DELAY;
                        press_d = 1'b1;
                        fire_d  = 1'b1;
                    end
                end
                DELAY: begin
                    if (!repeat_en_i) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == CW'(DAS_CYCLES - 1)) begin
                        state_d   = REPEAT;
                        rpt_cnt_d = '0;
                        fire_d    = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!repeat_en_i) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == CW'(ARR_CYCLES - 1)) begin
                        rpt_cnt_d = '0;
                        fire_d    = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = REL;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    assign btn_level_o = level_q;
    assign btn_press_o = press_q;
    assign btn_fire_o  = fire_q;

endmodule

// File: rtl/btn_autorepeat.sv
// Four independent debounced push-buttons with press pulse and auto-repeat fire.
module btn_autorepeat import btn_autorepeat_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DAS_CYCLES      = 8500000,
    parameter int ARR_CYCLES      = 2500000
) (
    input  logic             clk,
    input  logic             reset_n,
    btn_autorepeat_if.slave  bus
);

    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] fire_w;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DAS_CYCLES      (DAS_CYCLES),
            .ARR_CYCLES      (ARR_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .usr_btn_i   (bus.usr_btn[g]),
            .repeat_en_i (bus.repeat_en[g]),
            .btn_level_o (level_w[g]),
            .btn_press_o (press_w[g]),
            .btn_fire_o  (fire_w[g])
        );
    end

    assign bus.btn_level = level_w;
    assign bus.btn_press = press_w;
    assign bus.btn_fire  = fire_w;

endmodule
